// File: rtl/shift_pkg.sv
// Shared encodings for the shift datapath sequencers: command bus values,
// FSM states and default widths.
package shift_pkg;

  localparam int AMT_W_DEF = 5;
  localparam int OP_W_DEF  = 3;
  localparam int SEL_W_DEF = 2;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'b000,
    CMD_LOAD = 3'b001,
    CMD_SLL  = 3'b010,
    CMD_SRL  = 3'b011,
    CMD_SRA  = 3'b100,
    CMD_ROTR = 3'b101,
    CMD_ROTL = 3'b110
  } shift_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } shift_state_e;

  // Only the five real shift operations may reach the shift register.
  function automatic logic op_legal(input logic [2:0] op);
    return (op >= 3'b010) && (op <= 3'b110);
  endfunction

endpackage

// File: rtl/shift_amt_counter.sv
// Loadable down-counter shared by the shift, mult and div sequencers.
// Saturates at zero so a stray dec can never wrap.
module shift_amt_counter #(
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [AMT_W-1:0] load_val,
  output logic [AMT_W-1:0] value,
  output logic             last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - AMT_W'(1);
    end
  end

  assign last = (value == AMT_W'(1));

endmodule

// File: rtl/shift_ctrl.sv
// Multicycle sequencer for the shift-input mux and shift register.
// Define SHIFT_CTRL_MULTIBIT_EN to issue the whole amount in one SHIFT cycle.
module shift_ctrl
  import shift_pkg::*;
#(
  parameter int AMT_W = AMT_W_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] src_sel_in,
  input  logic [OP_W-1:0]  op_in,
  input  logic [AMT_W-1:0] amt_in,
  output logic [SEL_W-1:0] mux_sel,
  output logic [OP_W-1:0]  shift_cmd,
  output logic [AMT_W-1:0] shift_n,
  output logic             result_we,
  output logic             busy,
  output logic             done,
  output logic             op_err
);

  shift_state_e     state_q;
  logic [OP_W-1:0]  op_q;
  logic [AMT_W-1:0] cnt_value;
  logic             cnt_last;
  logic             cnt_load;
  logic             cnt_dec;
  logic             shift_exit;
  logic [AMT_W-1:0] shift_step;

  assign cnt_load = (state_q == ST_IDLE) && start;
  assign cnt_dec  = (state_q == ST_SHIFT);

  // The counter doubles as the captured amount: it holds amt_in through LOAD.
  shift_amt_counter #(.AMT_W(AMT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (amt_in),
    .value    (cnt_value),
    .last     (cnt_last)
  );

`ifdef SHIFT_CTRL_MULTIBIT_EN
  assign shift_exit = 1'b1;
  assign shift_step = cnt_value;
`else
  assign shift_exit = cnt_last;
  assign shift_step = AMT_W'(1);
`endif

  // Outputs are registered alongside the state so each reflects the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      mux_sel   <= '0;
      shift_cmd <= '0;
      shift_n   <= '0;
      result_we <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mux_sel   <= '0;
          shift_cmd <= OP_W'(CMD_NOP);
          shift_n   <= '0;
          result_we <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            op_q      <= op_in;
            op_err    <= !op_legal(3'(op_in));
            mux_sel   <= src_sel_in;
            shift_cmd <= OP_W'(CMD_LOAD);
            busy      <= 1'b1;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (op_legal(3'(op_q)) && (cnt_value != '0)) begin
            shift_cmd <= op_q;
            shift_n   <= shift_step;
            state_q   <= ST_SHIFT;
          end else begin
            shift_cmd <= OP_W'(CMD_NOP);
            result_we <= 1'b1;
            done      <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_SHIFT: begin
          if (shift_exit) begin
            shift_cmd <= OP_W'(CMD_NOP);
            shift_n   <= '0;
            result_we <= 1'b1;
            done      <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          mux_sel   <= '0;
          shift_cmd <= OP_W'(CMD_NOP);
          shift_n   <= '0;
          result_we <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl: vector table, random requests against a
// cycle-trace model, and hand-written reset/back-to-back sequences.
module tb_shift_ctrl;

`ifdef SHIFT_CTRL_MULTIBIT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] src_sel_in;
  logic [2:0] op_in;
  logic [4:0] amt_in;
  logic [1:0] mux_sel;
  logic [2:0] shift_cmd;
  logic [4:0] shift_n;
  logic       result_we;
  logic       busy;
  logic       done;
  logic       op_err;

  int  checks   = 0;
  int  failures = 0;
  bit  expErr   = 1'b0;

  typedef struct {
    logic [1:0] src;
    logic [2:0] op;
    logic [4:0] amt;
    int         mode;
    string      name;
  } vec_t;

  vec_t vecs[11];

  shift_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_sel_in (src_sel_in),
    .op_in      (op_in),
    .amt_in     (amt_in),
    .mux_sel    (mux_sel),
    .shift_cmd  (shift_cmd),
    .shift_n    (shift_n),
    .result_we  (result_we),
    .busy       (busy),
    .done       (done),
    .op_err     (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {mux_sel, shift_cmd, shift_n, result_we, done, busy, op_err}
  task automatic checkOutput(input string name, input int cyc,
                             input logic [13:0] exp, input logic [13:0] mask);
    logic [13:0] got;
    got = {mux_sel, shift_cmd, shift_n, result_we, done, busy, op_err};
    checks++;
    if ((got & mask) !== (exp & mask)) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %b required %b (mask %b)",
               name, cyc, got, exp, mask);
    end
  endtask

  // Issues one request and checks every cycle from LOAD through the first IDLE cycle.
  // mode 0: quiet inputs; 1: random inputs and start mid-op; 2: random inputs, start held high.
  task automatic applyStimulus(input logic [1:0] src, input logic [2:0] op,
                               input logic [4:0] amt, input int mode, input string name);
    int          k;
    bit          legal;
    logic [13:0] e;
    logic [13:0] m;
    logic [4:0]  step;
    legal  = (op >= 3'd2) && (op <= 3'd6);
    k      = (legal && amt != 5'd0) ? (MULTI ? 1 : int'(amt)) : 0;
    step   = MULTI ? amt : 5'd1;
    expErr = !legal;
    start      = 1'b1;
    src_sel_in = src;
    op_in      = op;
    amt_in     = amt;
    @(posedge clk);
    for (int c = 1; c <= k + 3; c++) begin
      @(negedge clk);
      m = '1;
      if (c == 1)
        e = {src, 3'b001, 5'd0, 3'b001, expErr};
      else if (c <= k + 1)
        e = {src, op, step, 3'b001, expErr};
      else if (c == k + 2) begin
        e = {2'b00, 3'b000, 5'd0, 3'b111, expErr};
        m[13:12] = 2'b00;
      end else
        e = {2'b00, 3'b000, 5'd0, 3'b000, expErr};
      checkOutput(name, c, e, m);
      if (mode != 0) begin
        src_sel_in = 2'($urandom);
        op_in      = 3'($urandom);
        amt_in     = 5'($urandom);
        start      = (mode == 2) ? 1'b1 : 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  // Aborts a long request partway through SHIFT and confirms it never completes.
  task automatic resetMidShift();
    int nShift;
    nShift     = MULTI ? 1 : 4;
    start      = 1'b1;
    src_sel_in = 2'd1;
    op_in      = 3'b010;
    amt_in     = 5'd10;
    @(posedge clk);
    start = 1'b0;
    repeat (1 + nShift) @(negedge clk);
    reset = 1'b0;
    #1;
    expErr = 1'b0;
    checkOutput("reset_mid_shift", 1 + nShift, 14'b0, '1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      checkOutput("no_done_after_abort", c, 14'b0, 14'b00_000_00000_1110);
    end
  endtask

  initial begin
    vecs[0]  = '{2'd2, 3'b010, 5'd3,  0, "sll_amt3"};
    vecs[1]  = '{2'd1, 3'b100, 5'd0,  0, "sra_amt0"};
    vecs[2]  = '{2'd3, 3'b111, 5'd5,  0, "illegal_111"};
    vecs[3]  = '{2'd0, 3'b011, 5'd1,  0, "srl_clears_err"};
    vecs[4]  = '{2'd2, 3'b101, 5'd2,  1, "rotr_noisy"};
    vecs[5]  = '{2'd1, 3'b000, 5'd4,  0, "illegal_000"};
    vecs[6]  = '{2'd3, 3'b001, 5'd0,  0, "illegal_001"};
    vecs[7]  = '{2'd2, 3'b011, 5'd17, 0, "srl_amt17"};
    vecs[8]  = '{2'd1, 3'b110, 5'd31, 2, "rotl_amt31_held"};
    vecs[9]  = '{2'd3, 3'b010, 5'd31, 2, "sll_amt31_held"};
    vecs[10] = '{2'd0, 3'b100, 5'd6,  1, "sra_noisy"};

    start      = 1'b0;
    src_sel_in = '0;
    op_in      = '0;
    amt_in     = '0;
    reset      = 1'b1;
    #2 reset   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 0, 14'b0, '1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", 0, 14'b0, '1);

    for (int i = 0; i < 11; i++)
      applyStimulus(vecs[i].src, vecs[i].op, vecs[i].amt, vecs[i].mode, vecs[i].name);

    for (int i = 0; i < 20; i++)
      applyStimulus(2'($urandom), 3'($urandom), 5'($urandom),
                    int'($urandom_range(0, 1)), "random");

    resetMidShift();
    applyStimulus(2'd2, 3'b011, 5'd2, 0, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
Name: shift_ctrl

Overview:
Multicycle sequencer for the shift datapath: the 4:1 shift-input mux feeding the shift register unit.
- Accepts one shift request: data source, operation and amount.
- Drives the mux selector, loads the shift register, then issues single-bit shift commands for the requested amount.
- Pulses a write-back strobe on completion.
- Sits between the main control unit FSM and the shift register, so the main FSM only waits on `done` instead of micro-sequencing shifts.

Parameters:
- AMT_W, 5, width of shift amount and internal down-counter.
- OP_W, 3, width of shift-register command bus.
- SEL_W, 2, width of shift-input mux selector (4 sources).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- src_sel_in  in  SEL_W  shift-input mux source for this operation.
- op_in  in  OP_W  requested operation: 010 sll, 011 srl, 100 sra, 101 rotr, 110 rotl.
- amt_in  in  AMT_W  shift amount, 0..31.
- mux_sel  out  SEL_W  selector to the shift-input mux.
- shift_cmd  out  OP_W  shift register command: 000 nop, 001 load, else op.
- shift_n  out  AMT_W  per-command shift distance to the shift register.
- result_we  out  1  write-back strobe for the shifted result.
- busy  out  1  high from the cycle after start is accepted until DONE completes.
- done  out  1  one-cycle completion pulse.
- op_err  out  1  sticky: last request had an illegal op; cleared by next accepted start.

Behaviour:
- Reset: state=IDLE, captured src/op/amt=0, counter=0; all outputs 0.
  - Reset asserted mid-operation aborts immediately: no done, no result_we.
- FSM states: IDLE, LOAD, SHIFT, DONE. Moore outputs decoded from registered state and captured fields.
- IDLE:
  - busy=0, shift_cmd=000, mux_sel=0.
  - On start=1: capture src_sel_in, op_in, amt_in; cnt<=amt_in; go LOAD.
- LOAD (1 cycle):
  - mux_sel=captured src, shift_cmd=001, busy=1.
  - Next state is SHIFT if op legal and amt!=0, else DONE.
  - Illegal op (000, 001, 111) sets op_err and skips SHIFT.
- SHIFT:
  - shift_cmd=captured op, shift_n=1, mux_sel held, busy=1.
  - cnt decrements each cycle; leave to DONE in the cycle cnt==1, so exactly amt SHIFT cycles.
- DONE (1 cycle):
  - shift_cmd=000, result_we=1, done=1, busy=1; next state IDLE.
  - result_we also asserted for amt=0 and for an illegal op: result is the loaded value.
- Latency: start sampled at edge 0 -> done high during cycle amt+2 (amt>=1), cycle 2 (amt=0).
- start while busy: ignored; not queued.
- start in the DONE cycle: ignored; the next request needs start high in IDLE.
- Inputs src_sel_in/op_in/amt_in are don't-care after capture; changes mid-operation have no effect.
- amt=31: 31 SHIFT cycles; no wrap of cnt (5-bit, starts at 31, exits at 1).

Optional Feature:
SHIFT_CTRL_MULTIBIT_EN
- Defined: SHIFT issues one cycle with shift_n=captured amt, using the shifter's full barrel capability; latency becomes 3 cycles for any amt>=1.
- Undefined: one-bit-per-cycle sequencing as above; shift_n is always 1 in SHIFT and 0 elsewhere.

Decomposition:
- Shared package shift_pkg: shift command encodings (NOP, LOAD, SLL, SRL, SRA, ROTR, ROTL), FSM state encoding, default widths.
- Sub-module: shift_amt_counter, a loadable AMT_W down-counter.
  - Inputs: load, dec.
  - Outputs: value, last (value==1).
  - Reused by the mult/div sequencers.

Test Plan:
- Reset mid-SHIFT (amt=10, reset low at 4th SHIFT cycle) -> outputs 0 within same cycle, state IDLE, no done.
- start, src=2, op=010, amt=3 -> LOAD with mux_sel=2, shift_cmd=001; then 3 cycles shift_cmd=010/shift_n=1; done+result_we in cycle 5; busy low cycle 6.
- amt=0, op=100 -> LOAD then DONE; done in cycle 2; no SHIFT cycle.
- op=111, amt=5 -> op_err=1, no SHIFT, done cycle 2; next legal start clears op_err.
- start held high continuously with amt=31 -> exactly 31 SHIFT cycles; second operation begins only after IDLE; inputs changed mid-op ignored.
- With SHIFT_CTRL_MULTIBIT_EN, op=011, amt=17 -> single SHIFT cycle with shift_n=17; done in cycle 3.
